// File: rtl/wb_pkg.sv
// Shared Wishbone responder types: FSM state encoding and bus field widths.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_ADDR_W = 30;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_BUSY = 2'd1,
        WB_S_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_ram_responder_if.sv
// Wishbone B4 pipelined bus bundle; names are from the responder's point of view.
interface wb_ram_responder_if;
    import wb_pkg::*;

    logic                 i_wb_cyc;
    logic                 i_wb_stb;
    logic                 i_wb_we;
    logic [WB_ADDR_W-1:0] i_wb_addr;
    logic [WB_DATA_W-1:0] i_wb_data;
    logic [WB_SEL_W-1:0]  i_wb_sel;
    logic [WB_DATA_W-1:0] o_wb_data;
    logic                 o_wb_ack;
    logic                 o_wb_stall;
    logic                 o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_data, o_wb_ack, o_wb_stall, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_data, o_wb_ack, o_wb_stall, o_wb_err
    );

endinterface

// File: rtl/wb_ram_bytewise.sv
// Word-organised RAM with per-byte-lane write enables and a registered read port.
module wb_ram_bytewise
    import wb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter     INIT_FILE = ""
) (
    input  logic                 i_clk,
    input  logic [WB_SEL_W-1:0]  i_we,
    input  logic                 i_re,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [WB_DATA_W-1:0] i_wdata,
    output logic [WB_DATA_W-1:0] o_rdata
);

    logic [WB_DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WB_DATA_W-1:0] r_rdata;

    // Read port only updates on a read request so the word holds through the latency.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < WB_SEL_W; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined RAM responder, one request outstanding, configurable read latency.
// Optional macro WB_RAM_ERR_EN: out-of-range word addresses terminate with err instead of aliasing.
module wb_ram_responder
    import wb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter     INIT_FILE = ""
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    wb_ram_responder_if.slave  wb
);

    wb_state_e            r_state, w_state_nxt;
    logic [1:0]           r_cnt, w_cnt_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_rd_ok, w_rd_ok_nxt;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_addr_bad;
    logic [WB_SEL_W-1:0]  w_ram_we;
    logic                 w_ram_re;
    logic [WB_DATA_W-1:0] w_ram_rdata;

`ifdef WB_RAM_ERR_EN
    assign w_addr_bad = |wb.i_wb_addr[WB_ADDR_W-1:ADDR_W];
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^wb.i_wb_addr[WB_ADDR_W-1:ADDR_W];
    assign w_addr_bad       = 1'b0;
`endif

    assign w_stall  = (r_state == WB_S_BUSY);
    // Reset gates acceptance so a strobe held through reset cannot touch the RAM.
    assign w_accept = i_reset_n && wb.i_wb_cyc && wb.i_wb_stb && !w_stall;
    assign w_ram_we = (w_accept && wb.i_wb_we && !w_addr_bad) ? wb.i_wb_sel : '0;
    assign w_ram_re = w_accept && !wb.i_wb_we && !w_addr_bad;

    wb_ram_bytewise #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (wb.i_wb_addr[ADDR_W-1:0]),
        .i_wdata (wb.i_wb_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= WB_S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_rd_ok <= w_rd_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_rd_ok_nxt = r_rd_ok;
        case (r_state)
            WB_S_BUSY: begin
                if (!wb.i_wb_cyc) begin
                    w_state_nxt = WB_S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 2'd0) begin
                    w_state_nxt = WB_S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = WB_S_IDLE;
                if (w_accept) begin
                    w_err_nxt   = w_addr_bad;
                    w_rd_ok_nxt = !wb.i_wb_we && !w_addr_bad;
                    if (wb.i_wb_we || READ_LAT == 1) begin
                        w_state_nxt = WB_S_RESP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = WB_S_BUSY;
                        w_cnt_nxt   = 2'(READ_LAT - 2);
                    end
                end
            end
        endcase
    end

    assign wb.o_wb_stall = w_stall;
    assign wb.o_wb_ack   = (r_state == WB_S_RESP) && wb.i_wb_cyc && !r_err;
    assign wb.o_wb_data  = r_rd_ok ? w_ram_rdata : '0;
`ifdef WB_RAM_ERR_EN
    assign wb.o_wb_err   = (r_state == WB_S_RESP) && wb.i_wb_cyc && r_err;
`else
    assign wb.o_wb_err   = 1'b0;
`endif

endmodule
